// File: rtl/gate_bist_checker_if.sv
// rtl/gate_bist_checker_if.sv - stimulus/response and result bundle of the gate BIST checker
interface gate_bist_checker_if;
  logic       start;
  logic       a_out;
  logic       b_out;
  logic [6:0] gate_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [1:0] fail_vec;
  logic [6:0] fail_mask;

  // Controller side: drives start and the observed gate responses.
  modport master (
    output start,
    output gate_in,
    input  a_out,
    input  b_out,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  fail_vec,
    input  fail_mask
  );

  // Checker side: drives stimulus and results.
  modport slave (
    input  start,
    input  gate_in,
    output a_out,
    output b_out,
    output busy,
    output done,
    output pass,
    output err_count,
    output fail_vec,
    output fail_mask
  );
endinterface

// File: rtl/gate_bist_checker.sv
// rtl/gate_bist_checker.sv - exhaustive 2-input BIST of an AND/OR/NOT/NAND/NOR/XOR/XNOR gate set
module gate_bist_checker #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned LOOPS         = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  gate_bist_checker_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LOOP_LAST   = 8'(LOOPS - 1);

  state_t     state_q, state_d;
  // The current vector {a,b} doubles as the registered stimulus outputs.
  logic [1:0] vec_q, vec_d;
  logic [7:0] settle_q, settle_d;
  logic [7:0] loop_q, loop_d;
  logic [7:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic [1:0] fail_vec_q, fail_vec_d;
  logic [6:0] fail_mask_q, fail_mask_d;

  logic [6:0] expected;
  logic [6:0] mismatch;
  logic [2:0] mis_pop;
  logic [8:0] err_sum;
  logic [7:0] err_sat;

  // Reference responses for the vector currently applied, and the saturating error sum.
  always_comb begin
    expected = {vec_q[1] & vec_q[0],
                vec_q[1] | vec_q[0],
                ~vec_q[1],
                ~(vec_q[1] & vec_q[0]),
                ~(vec_q[1] | vec_q[0]),
                vec_q[1] ^ vec_q[0],
                ~(vec_q[1] ^ vec_q[0])};
    mismatch = bus.gate_in ^ expected;
    mis_pop  = 3'd0;
    for (int i = 0; i < 7; i++) begin
      mis_pop = mis_pop + 3'(mismatch[i]);
    end
    err_sum = {1'b0, err_q} + 9'(mis_pop);
    err_sat = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  // Next-state and datapath updates; everything holds unless the state says otherwise.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    settle_d    = settle_q;
    loop_d      = loop_q;
    err_d       = err_q;
    pass_d      = pass_q;
    fail_vec_d  = fail_vec_q;
    fail_mask_d = fail_mask_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = SETTLE;
          vec_d       = 2'b00;
          settle_d    = 8'd0;
          loop_d      = 8'd0;
          err_d       = 8'd0;
          pass_d      = 1'b0;
          fail_vec_d  = 2'b00;
          fail_mask_d = 7'd0;
        end
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = SAMPLE;
          settle_d = 8'd0;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      SAMPLE: begin
        err_d = err_sat;
        // A zero error count means no earlier vector of this run has failed.
        if ((mismatch != 7'd0) && (err_q == 8'd0)) begin
          fail_vec_d  = vec_q;
          fail_mask_d = mismatch;
        end
        // Incrementing wraps 11 back to 00, which is also the parked value in DONE.
        vec_d   = vec_q + 2'd1;
        state_d = SETTLE;
        if (vec_q == 2'b11) begin
          if (loop_q == LOOP_LAST) begin
            state_d = DONE;
            pass_d  = (err_sat == 8'd0);
          end else begin
            loop_d = loop_q + 8'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      vec_q       <= 2'b00;
      settle_q    <= 8'd0;
      loop_q      <= 8'd0;
      err_q       <= 8'd0;
      pass_q      <= 1'b0;
      fail_vec_q  <= 2'b00;
      fail_mask_q <= 7'd0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      settle_q    <= settle_d;
      loop_q      <= loop_d;
      err_q       <= err_d;
      pass_q      <= pass_d;
      fail_vec_q  <= fail_vec_d;
      fail_mask_q <= fail_mask_d;
    end
  end

  assign bus.a_out     = vec_q[1];
  assign bus.b_out     = vec_q[0];
  assign bus.busy      = (state_q == SETTLE) || (state_q == SAMPLE);
  assign bus.done      = (state_q == DONE);
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_vec  = fail_vec_q;
  assign bus.fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate_bist_checker.sv
// tb/tb_gate_bist_checker.sv - randomized model-based bench for gate_bist_checker
module tb_gate_bist_checker;

  localparam int S0 = 1;
  localparam int L0 = 1;
  localparam int S1 = 2;
  localparam int L1 = 10;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;

  gate_bist_checker_if if0 ();
  gate_bist_checker_if if1 ();

  gate_bist_checker dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  gate_bist_checker #(.SETTLE_CYCLES(S1), .LOOPS(L1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Injected fault per instance and per vector: observed = truth ^ fm.
  logic [6:0] fm [2][4];

  // Model state: accepted start edge, expected run results, and what the outputs display.
  bit act [2];
  int k [2];
  int m_err [2], m_fv [2], m_fm [2], m_pass [2];
  int d_err [2], d_fv [2], d_fm [2], d_pass [2];

  logic       busy_a [2], done_a [2], pass_a [2];
  logic [1:0] ab_a [2], fv_a [2];
  logic [7:0] ec_a [2];
  logic [6:0] fmk_a [2];

  function automatic int sp(int w);
    return (w == 0) ? S0 : S1;
  endfunction

  function automatic int lp(int w);
    return (w == 0) ? L0 : L1;
  endfunction

  function automatic int run_len(int w);
    return 4 * lp(w) * (sp(w) + 1);
  endfunction

  // Truth tables indexed by {a,b}.
  function automatic logic [6:0] golden(logic [1:0] v);
    logic [3:0] t_and, t_or, t_nota, t_nand, t_nor, t_xor, t_xnor;
    t_and  = 4'b1000;
    t_or   = 4'b1110;
    t_nota = 4'b0011;
    t_nand = 4'b0111;
    t_nor  = 4'b0001;
    t_xor  = 4'b0110;
    t_xnor = 4'b1001;
    return {t_and[v], t_or[v], t_nota[v], t_nand[v], t_nor[v], t_xor[v], t_xnor[v]};
  endfunction

  always_comb begin
    if0.gate_in = golden({if0.a_out, if0.b_out}) ^ fm[0][{if0.a_out, if0.b_out}];
    if1.gate_in = golden({if1.a_out, if1.b_out}) ^ fm[1][{if1.a_out, if1.b_out}];
  end

  always_comb begin
    busy_a[0] = if0.busy;      busy_a[1] = if1.busy;
    done_a[0] = if0.done;      done_a[1] = if1.done;
    pass_a[0] = if0.pass;      pass_a[1] = if1.pass;
    ab_a[0]   = {if0.a_out, if0.b_out};
    ab_a[1]   = {if1.a_out, if1.b_out};
    fv_a[0]   = if0.fail_vec;  fv_a[1]  = if1.fail_vec;
    ec_a[0]   = if0.err_count; ec_a[1]  = if1.err_count;
    fmk_a[0]  = if0.fail_mask; fmk_a[1] = if1.fail_mask;
  end

  task automatic chk(string nm, int w, int act_v, int exp_v);
    total++;
    if (act_v != exp_v) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0d want=%0d", nm, w, cyc, act_v, exp_v);
    end
  endtask

  // Whole-run outcome from the fault table: every pass repeats the same 4 vectors.
  function automatic void calc(int w);
    int e;
    bit found;
    e = 0;
    found = 0;
    m_fv[w] = 0;
    m_fm[w] = 0;
    for (int v = 0; v < 4; v++) begin
      int pc;
      pc = $countones(fm[w][v]);
      e += pc;
      if (!found && pc != 0) begin
        found = 1;
        m_fv[w] = v;
        m_fm[w] = int'(fm[w][v]);
      end
    end
    e = e * lp(w);
    if (e > 255) e = 255;
    m_err[w]  = e;
    m_pass[w] = (e == 0) ? 1 : 0;
  endfunction

  task automatic chk_results(int w);
    chk("err_count", w, int'(ec_a[w]), d_err[w]);
    chk("fail_vec",  w, int'(fv_a[w]), d_fv[w]);
    chk("fail_mask", w, int'(fmk_a[w]), d_fm[w]);
    chk("pass",      w, int'(pass_a[w]), d_pass[w]);
  endtask

  // Cycle-by-cycle comparison against the run timeline t = cycles since the start edge.
  always @(negedge clk) begin
    for (int w = 0; w < 2; w++) begin
      int t;
      int n;
      n = run_len(w);
      t = cyc - k[w];
      if (act[w] && t >= 0 && t < n) begin
        chk("busy_run", w, int'(busy_a[w]), 1);
        chk("done_run", w, int'(done_a[w]), 0);
        chk("vector",   w, int'(ab_a[w]), (t / (sp(w) + 1)) % 4);
      end else if (act[w] && t == n) begin
        d_err[w]  = m_err[w];
        d_fv[w]   = m_fv[w];
        d_fm[w]   = m_fm[w];
        d_pass[w] = m_pass[w];
        chk("done_pulse", w, int'(done_a[w]), 1);
        chk("busy_done",  w, int'(busy_a[w]), 0);
        chk("ab_done",    w, int'(ab_a[w]), 0);
        chk_results(w);
      end else begin
        chk("busy_idle", w, int'(busy_a[w]), 0);
        chk("done_idle", w, int'(done_a[w]), 0);
        chk("ab_idle",   w, int'(ab_a[w]), 0);
        chk_results(w);
      end
    end
  end

  // Called at a negedge; start is held for exactly one cycle.
  task automatic pulse_start(int w);
    if (!act[w] || (cyc - k[w]) > run_len(w)) begin
      act[w] = 1;
      k[w]   = cyc + 1;
      calc(w);
    end
    if (w == 0) if0.start = 1'b1;
    else        if1.start = 1'b1;
    @(negedge clk);
    if (w == 0) if0.start = 1'b0;
    else        if1.start = 1'b0;
  endtask

  task automatic run(int w, bit repulse);
    pulse_start(w);
    repeat (run_len(w) + 1) begin
      if (repulse && ((cyc - k[w]) == run_len(w) || $urandom_range(0, 3) == 0))
        pulse_start(w);
      else
        @(negedge clk);
    end
  endtask

  task automatic set_masks(int w, int mode);
    for (int v = 0; v < 4; v++) begin
      case (mode)
        0: fm[w][v] = 7'h00;
        1: fm[w][v] = golden(2'(v)) & 7'h40;
        2: fm[w][v] = 7'h7F;
        default: fm[w][v] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'($urandom);
      endcase
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    if0.start = 1'b0;
    if1.start = 1'b0;
    for (int w = 0; w < 2; w++) begin
      act[w] = 0; k[w] = 0;
      m_err[w] = 0; m_fv[w] = 0; m_fm[w] = 0; m_pass[w] = 0;
      d_err[w] = 0; d_fv[w] = 0; d_fm[w] = 0; d_pass[w] = 0;
      set_masks(w, 0);
    end
    repeat (2) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      chk("rst_busy", w, int'(busy_a[w]), 0);
      chk("rst_done", w, int'(done_a[w]), 0);
      chk("rst_ab",   w, int'(ab_a[w]), 0);
      chk("rst_err",  w, int'(ec_a[w]), 0);
      chk("rst_pass", w, int'(pass_a[w]), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    set_masks(0, 0);
    run(0, 0);
    chk("good_err", 0, int'(ec_a[0]), 0);
    chk("good_pass", 0, int'(pass_a[0]), 1);

    set_masks(0, 1);
    run(0, 0);
    chk("and_sa0_err",  0, int'(ec_a[0]), 1);
    chk("and_sa0_vec",  0, int'(fv_a[0]), 3);
    chk("and_sa0_mask", 0, int'(fmk_a[0]), 7'h40);
    chk("and_sa0_pass", 0, int'(pass_a[0]), 0);

    set_masks(0, 2);
    run(0, 0);
    chk("inv_err",  0, int'(ec_a[0]), 28);
    chk("inv_vec",  0, int'(fv_a[0]), 0);
    chk("inv_mask", 0, int'(fmk_a[0]), 7'h7F);

    set_masks(1, 2);
    run(1, 0);
    chk("inv10_err", 1, int'(ec_a[1]), 255);
    chk("inv10_pass", 1, int'(pass_a[1]), 0);

    set_masks(0, 0);
    run(0, 1);
    chk("repulse_pass", 0, int'(pass_a[0]), 1);

    // Abort during vector 10, then restart on the first edge after release.
    pulse_start(0);
    for (int i = 0; i < 20 && ab_a[0] != 2'b10; i++) @(negedge clk);
    chk("reach_vec10", 0, int'(ab_a[0]), 2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int w = 0; w < 2; w++) begin
      act[w] = 0;
      d_err[w] = 0; d_fv[w] = 0; d_fm[w] = 0; d_pass[w] = 0;
    end
    #1;
    chk("abort_ab",   0, int'(ab_a[0]), 0);
    chk("abort_busy", 0, int'(busy_a[0]), 0);
    chk("abort_done", 0, int'(done_a[0]), 0);
    chk("abort_err",  0, int'(ec_a[0]), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(0, 0);
    chk("after_abort_pass", 0, int'(pass_a[0]), 1);

    for (int r = 0; r < 8; r++) begin
      set_masks(0, 3);
      run(0, bit'($urandom_range(0, 1)));
    end
    for (int r = 0; r < 2; r++) begin
      set_masks(1, 3);
      run(1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
